trading_engine_core: RTL and testbench
======================================

// Module: trading_engine_core
// PURPOSE
//  Self-contained low-latency trading demo engine for the 125 MHz board clock.
//  - Generates an internal pseudo-random market price feed.
//  - Runs a threshold strategy with a position limit.
//  - Frames each order in an order-entry FSM with a loopback ack.
//  - Reports health and activity on 8 status LEDs. No external data I/O.
// PARAMETERS
//  TICK_DIV     125      clocks per market tick (1 us at 125 MHz)
//  HB_DIV       62500    clocks per heartbeat LED toggle (0.5 ms)
//  LFSR_SEED    16'hACE1 market LFSR reset value; must be nonzero
//  BUY_THRESH   256      buy when price < BUY_THRESH
//  SELL_THRESH  767      sell when price > SELL_THRESH
//  POS_LIMIT    8        max |position| in lots
//  FRAME_LEN    8        order frame length in bytes (cycles in SEND)
//  ACK_LAT      4        clocks from last frame byte to loopback ack
// PORTS
//  clk_125mhz   in   1  system clock, 125 MHz; all logic in this domain
//  rstn_raw     in   1  async active-low reset from the board
//  status_leds  out  8  status indicators
//    [0] heartbeat
//    [1] reset released
//    [2] order FSM busy
//    [3] last side (1 = buy)
//    [4] position at +/-POS_LIMIT
//    [7:5] orders-sent count mod 8
// BEHAVIOUR
//  Clock and reset
//  - One clock; reset is asynchronous and active-low.
//  - rstn_raw asserts all state immediately. Release is synchronized by a 2-flop
//    synchronizer, so internal rst_n rises on the 2nd clk_125mhz edge after
//    rstn_raw rises.
//  - Reset values: status_leds=0, all counters=0, LFSR=LFSR_SEED, position=0,
//    FSM=IDLE, last side=0.
//  - Reset asserted mid-frame aborts the frame; no partial order is counted.
//  Market feed
//  - Tick counter runs 0..TICK_DIV-1. tick is a 1-cycle pulse when count==TICK_DIV-1.
//  - The first tick occurs TICK_DIV cycles after internal reset release.
//  - On tick, a 16-bit Fibonacci LFSR (taps 16,14,13,11; shift left, feedback into
//    bit0) advances once. price = lfsr[9:0], range 0..1023.
//  Strategy
//  - Evaluated in the cycle after tick, on the updated price:
//    - buy  if price < BUY_THRESH and position <  +POS_LIMIT
//    - sell if price > SELL_THRESH and position > -POS_LIMIT
//    - otherwise none.
//  - A request is issued only if the FSM is IDLE. Otherwise it is dropped and an
//    internal 16-bit drop counter increments (saturating).
//  Order FSM
//  - IDLE -> BUILD (1 clk): latch side, price, order_id.
//  - BUILD -> SEND: FRAME_LEN clks, one byte per clk.
//    Frame: {0xA5, side, id[15:8], id[7:0], price[9:8], price[7:0], 0x00, xor of
//    bytes 0..6}.
//  - SEND -> WAIT_ACK: ACK_LAT clks.
//  - WAIT_ACK -> IDLE: on ack.
//  - On ack: order_id += 1 (16-bit wrap), orders-sent += 1, position +1 for buy or
//    -1 for sell, led[3] = side.
//  - Decision-to-IDLE latency: 1 + FRAME_LEN + ACK_LAT clks (13 with defaults).
//  LEDs
//  - led[0] toggles every HB_DIV clks.
//  - led[1] = internal rst_n.
//  - led[2] = FSM != IDLE.
//  - led[4] = (position == +/-POS_LIMIT).
//  - led[7:5] = orders_sent[2:0].
//  - All LED outputs are registered.
// TESTING
//  1 Assert rstn_raw=0 for 100 ns, then release -> all LEDs 0 during reset;
//    led[1]=1 within 2 clks of release; led[2]=0.
//  2 Free-run 1 ms -> led[0] toggles at 0.5 ms after release. A bench LFSR model
//    matches every price. leds[7:5] equals the model order count mod 8.
//  3 BUY_THRESH=1024, SELL_THRESH=1023 -> exactly 8 buys, then stop. Position=8,
//    led[4]=1, led[3]=1, led[7:5]=0.
//  4 TICK_DIV=8 (shorter than the 13-clk order path) -> alternate decisions are
//    dropped; drop counter increments; no frame is corrupted.
//  5 Pulse rstn_raw low during SEND -> outputs 0 at once; after release there is
//    no ack, orders_sent=0, LFSR=LFSR_SEED.
//  6 Check every frame byte 7 against the xor of bytes 0..6, and check id
//    increments by 1 per order.

Source files
------------

// File: rtl/trading_engine_core.sv
// Trading demo engine: LFSR market feed, threshold strategy with a position limit,
// order-entry FSM with a loopback ack, and registered status LEDs.
package trading_engine_core_pkg;
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_BUILD    = 2'd1,
      ST_SEND     = 2'd2,
      ST_WAIT_ACK = 2'd3
   } state_e;

   typedef struct packed {
      state_e             state;
      logic               tick;
      logic               eval;
      logic               frame_valid;
      logic [7:0]         frame_byte;
      logic               ack;
      logic [15:0]        order_id;
      logic [15:0]        orders_sent;
      logic signed [7:0]  position;
      logic [15:0]        drop_cnt;
      logic [15:0]        lfsr;
   } dbg_t;
endpackage

module trading_engine_core
   import trading_engine_core_pkg::*;
#(
   parameter int          TICK_DIV    = 125,
   parameter int          HB_DIV      = 62500,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter int          BUY_THRESH  = 256,
   parameter int          SELL_THRESH = 767,
   parameter int          POS_LIMIT   = 8,
   parameter int          FRAME_LEN   = 8,
   parameter int          ACK_LAT     = 4
) (
   input  logic       clk_125mhz,
   input  logic       rstn_raw,
   output logic [7:0] status_leds,
   output dbg_t       o_dbg
);

   localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HBW = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
   localparam int PW  = $clog2(POS_LIMIT + 1) + 1;
   localparam logic [TCW-1:0]       TICK_LAST  = TCW'(TICK_DIV - 1);
   localparam logic [HBW-1:0]       HB_LAST    = HBW'(HB_DIV - 1);
   localparam logic [10:0]          BUY_T      = 11'(BUY_THRESH);
   localparam logic [10:0]          SELL_T     = 11'(SELL_THRESH);
   localparam logic signed [PW-1:0] POS_MAX    = PW'(POS_LIMIT);
   localparam logic signed [PW-1:0] POS_MIN    = PW'(-POS_LIMIT);
   localparam logic [7:0]           FRAME_LAST = 8'(FRAME_LEN - 1);
   localparam logic [7:0]           ACK_LAST   = 8'(ACK_LAT - 1);

   logic [1:0]           r_sync;
   logic                 w_rst_n;
   logic [TCW-1:0]       r_tick_cnt;
   logic                 w_tick;
   logic                 r_eval;
   logic [15:0]          r_lfsr;
   logic [9:0]           w_price;
   logic [10:0]          w_price_x;
   logic                 w_buy, w_sell, w_want, w_req, w_drop;
   state_e               r_state, w_state_nxt;
   logic                 w_ack;
   logic [7:0]           r_phase;
   logic                 r_side;
   logic [9:0]           r_ord_price;
   logic [15:0]          r_ord_id;
   logic [15:0]          r_order_id;
   logic [15:0]          r_sent;
   logic signed [PW-1:0] r_pos, w_pos_nxt;
   logic                 r_last_side;
   logic [15:0]          r_drop;
   logic [HBW-1:0]       r_hb_cnt;
   logic                 r_hb, r_busy, r_at_lim;
   logic [7:0]           w_chk, w_frame_byte;

   // Release is synchronized; assertion reaches every flop asynchronously via w_rst_n.
   always_ff @(posedge clk_125mhz or negedge rstn_raw) begin
      if (!rstn_raw) r_sync <= 2'b00;
      else           r_sync <= {r_sync[0], 1'b1};
   end
   assign w_rst_n = r_sync[1];

   assign w_tick    = (r_tick_cnt == TICK_LAST);
   assign w_price   = r_lfsr[9:0];
   assign w_price_x = {1'b0, w_price};

   always_ff @(posedge clk_125mhz or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_tick_cnt <= '0;
         r_eval     <= 1'b0;
         r_lfsr     <= LFSR_SEED;
      end else begin
         r_eval <= w_tick;
         if (w_tick) begin
            r_tick_cnt <= '0;
            r_lfsr     <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
         end else begin
            r_tick_cnt <= r_tick_cnt + TCW'(1);
         end
      end
   end

   // Strategy runs one cycle after the tick, so it sees the freshly advanced price.
   assign w_buy  = r_eval && (w_price_x < BUY_T) && (r_pos < POS_MAX);
   assign w_sell = r_eval && !w_buy && (w_price_x > SELL_T) && (r_pos > POS_MIN);
   assign w_want = w_buy | w_sell;
   assign w_req  = w_want && (r_state == ST_IDLE);
   assign w_drop = w_want && (r_state != ST_IDLE);

   always_ff @(posedge clk_125mhz or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Frame stream: frame_valid/frame_byte carry one byte per SEND cycle with no
   // back-pressure; the loopback ack is a single-cycle pulse in the last WAIT_ACK cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_ack       = 1'b0;
      case (r_state)
         ST_IDLE:     if (w_req) w_state_nxt = ST_BUILD;
         ST_BUILD:    w_state_nxt = ST_SEND;
         ST_SEND:     if (r_phase == FRAME_LAST) w_state_nxt = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (r_phase == ACK_LAST) begin
               w_ack       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default:     w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_pos_nxt = r_pos;
      if (w_ack) w_pos_nxt = r_side ? r_pos + PW'(1) : r_pos - PW'(1);
   end

   always_ff @(posedge clk_125mhz or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_phase     <= '0;
         r_side      <= 1'b0;
         r_ord_price <= '0;
         r_ord_id    <= '0;
         r_order_id  <= '0;
         r_sent      <= '0;
         r_pos       <= '0;
         r_last_side <= 1'b0;
         r_drop      <= '0;
      end else begin
         if ((r_state == ST_IDLE) || (w_state_nxt != r_state)) r_phase <= '0;
         else                                                 r_phase <= r_phase + 8'd1;
         if (w_req) begin
            r_side      <= w_buy;
            r_ord_price <= w_price;
            r_ord_id    <= r_order_id;
         end
         if (w_ack) begin
            r_order_id  <= r_order_id + 16'd1;
            r_sent      <= r_sent + 16'd1;
            r_last_side <= r_side;
         end
         r_pos <= w_pos_nxt;
         if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
      end
   end

   assign w_chk = 8'hA5 ^ {7'd0, r_side} ^ r_ord_id[15:8] ^ r_ord_id[7:0]
                ^ {6'd0, r_ord_price[9:8]} ^ r_ord_price[7:0];

   always_comb begin
      w_frame_byte = 8'h00;
      case (r_phase)
         8'd0:    w_frame_byte = 8'hA5;
         8'd1:    w_frame_byte = {7'd0, r_side};
         8'd2:    w_frame_byte = r_ord_id[15:8];
         8'd3:    w_frame_byte = r_ord_id[7:0];
         8'd4:    w_frame_byte = {6'd0, r_ord_price[9:8]};
         8'd5:    w_frame_byte = r_ord_price[7:0];
         8'd7:    w_frame_byte = w_chk;
         default: w_frame_byte = 8'h00;
      endcase
   end

   // LED bits are loaded from next-state values so they line up with the state they report.
   always_ff @(posedge clk_125mhz or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_hb_cnt <= '0;
         r_hb     <= 1'b0;
         r_busy   <= 1'b0;
         r_at_lim <= 1'b0;
      end else begin
         if (r_hb_cnt == HB_LAST) begin
            r_hb_cnt <= '0;
            r_hb     <= ~r_hb;
         end else begin
            r_hb_cnt <= r_hb_cnt + HBW'(1);
         end
         r_busy   <= (w_state_nxt != ST_IDLE);
         r_at_lim <= (w_pos_nxt == POS_MAX) || (w_pos_nxt == POS_MIN);
      end
   end

   assign status_leds = {r_sent[2:0], r_at_lim, r_last_side, r_busy, r_sync[1], r_hb};

   always_comb begin
      o_dbg             = '0;
      o_dbg.state       = r_state;
      o_dbg.tick        = w_tick;
      o_dbg.eval        = r_eval;
      o_dbg.frame_valid = (r_state == ST_SEND);
      o_dbg.frame_byte  = w_frame_byte;
      o_dbg.ack         = w_ack;
      o_dbg.order_id    = r_order_id;
      o_dbg.orders_sent = r_sent;
      o_dbg.position    = 8'(r_pos);
      o_dbg.drop_cnt    = r_drop;
      o_dbg.lfsr        = r_lfsr;
   end

endmodule

// File: tb/tb_trading_engine_core.sv
// Bench for trading_engine_core: default-threshold instance checked against an LFSR/strategy
// model, plus an always-buy instance with an 8-clock tick that overruns the order path.
module tb_trading_engine_core;
   import trading_engine_core_pkg::*;

   localparam int          HB   = 1000;
   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       rstn_raw = 1'b0;
   logic [7:0] leds_a, leds_b;
   dbg_t       dbg_a, dbg_b;

   always #4 clk = ~clk;

   trading_engine_core #(.TICK_DIV(125), .HB_DIV(HB)) dut_a (
      .clk_125mhz(clk), .rstn_raw(rstn_raw), .status_leds(leds_a), .o_dbg(dbg_a));

   trading_engine_core #(.TICK_DIV(8), .HB_DIV(HB), .BUY_THRESH(1024), .SELL_THRESH(1023)) dut_b (
      .clk_125mhz(clk), .rstn_raw(rstn_raw), .status_leds(leds_b), .o_dbg(dbg_b));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- model ----------------
   logic [63:0] exp_q[$];
   logic [15:0] m_lfsr = SEED;
   int          m_pos  = 0;
   logic [15:0] m_id   = 16'd0;
   int          m_ev   = 0;
   int          hand_price [4] = '{451, 903, 783, 542};

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [63:0] make_frame(input logic side, input logic [15:0] id,
                                              input logic [9:0] p);
      logic [7:0]  b [8];
      logic [63:0] f;
      b[0] = 8'hA5; b[1] = {7'd0, side}; b[2] = id[15:8]; b[3] = id[7:0];
      b[4] = {6'd0, p[9:8]}; b[5] = p[7:0]; b[6] = 8'h00; b[7] = 8'h00;
      for (int i = 0; i < 7; i++) b[7] = b[7] ^ b[i];
      f = '0;
      for (int i = 0; i < 8; i++) f = {f[55:0], b[i]};
      return f;
   endfunction

   // n = negedge index after release; evals fall on n = 127, 252, ...
   task automatic model_step(input int n);
      logic [9:0] p;
      if (n >= 127 && ((n - 2) % 125) == 0) begin
         m_lfsr = lfsr_step(m_lfsr);
         p = m_lfsr[9:0];
         check("lfsr_model", dbg_a.lfsr, m_lfsr);
         if (m_ev < 4) check("price_hand", p, hand_price[m_ev]);
         m_ev++;
         if (p < 10'd256 && m_pos < 8) begin
            exp_q.push_back(make_frame(1'b1, m_id, p));
            m_pos++; m_id++;
         end else if (p > 10'd767 && m_pos > -8) begin
            exp_q.push_back(make_frame(1'b0, m_id, p));
            m_pos--; m_id++;
         end
      end
   endtask

   // ---------------- frame scoreboard ----------------
   logic [63:0] fbuf [2];
   int          fcnt [2]    = '{0, 0};
   int          prev_id [2] = '{-1, -1};
   int          frames [2]  = '{0, 0};

   task automatic frame_done(input int k, input logic [63:0] f);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 7; i++) x = x ^ f[63 - 8*i -: 8];
      check("frame_xor", f[7:0], x);
      check("frame_id_inc", f[47:32], 16'(prev_id[k] + 1));
      prev_id[k] = int'(f[47:32]);
      if (k == 0) begin
         if (frames[0] == 0) check("frame0_hand", f, 64'hA500_0000_0387_0021);
         if (frames[0] == 1) check("frame1_hand", f, 64'hA500_0001_030F_00A8);
         check("frame_expected", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) check("frame_model", f, exp_q.pop_front());
      end else begin
         check("b_side_buy", f[55:48], 8'h01);
      end
      frames[k]++;
   endtask

   task automatic collect(input int k, input dbg_t d);
      if (!rstn_raw) begin
         fcnt[k] = 0;
         prev_id[k] = -1;
      end else if (d.frame_valid) begin
         fbuf[k] = {fbuf[k][55:0], d.frame_byte};
         fcnt[k]++;
         if (fcnt[k] == 8) begin
            frame_done(k, fbuf[k]);
            fcnt[k] = 0;
         end
      end else begin
         fcnt[k] = 0;
      end
   endtask

   always @(negedge clk) begin
      collect(0, dbg_a);
      collect(1, dbg_b);
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int fr_before;
      n = 0;
      rstn_raw = 1'b0;
      repeat (12) @(negedge clk);
      check("rst_leds_a", leds_a, 8'h00);
      check("rst_leds_b", leds_b, 8'h00);
      check("rst_lfsr_a", dbg_a.lfsr, SEED);
      check("rst_state_a", dbg_a.state, ST_IDLE);
      rstn_raw = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         n++;
         model_step(n);
         if (n == 1) check("led1_n1", leds_a[1], 1'b0);
         if (n == 2) begin
            check("led1_rel_a", leds_a[1], 1'b1);
            check("led2_idle_a", leds_a[2], 1'b0);
            check("led1_rel_b", leds_b[1], 1'b1);
         end
         if (n == 125) check("tick_early", dbg_a.tick, 1'b0);
         if (n == 126) begin
            check("tick_first", dbg_a.tick, 1'b1);
            check("lfsr_pre_tick", dbg_a.lfsr, SEED);
         end
         if (n == 253) check("busy_build", leds_a[2], 1'b1);
         if (n == 265) begin
            check("busy_last", leds_a[2], 1'b1);
            check("sent_before_ack", leds_a[7:5], 3'd0);
         end
         if (n == 266) begin
            check("idle_after_13", leds_a[2], 1'b0);
            check("sent_after_ack", leds_a[7:5], 3'd1);
            check("side_sell", leds_a[3], 1'b0);
            check("pos_after_sell", {56'd0, dbg_a.position}, 64'hFF);
         end
         if (n == 400) begin
            check("b_orders", dbg_b.orders_sent, 16'd8);
            check("b_position", {56'd0, dbg_b.position}, 64'd8);
            check("b_drops", dbg_b.drop_cnt, 16'd8);
            check("b_frames", frames[1], 8);
            check("b_led4_limit", leds_b[4], 1'b1);
            check("b_led3_buy", leds_b[3], 1'b1);
            check("b_led75", leds_b[7:5], 3'd0);
            check("b_led2_idle", leds_b[2], 1'b0);
         end
         if (n == HB + 1)     check("hb_before", leds_a[0], 1'b0);
         if (n == HB + 2)     check("hb_toggle1", leds_a[0], 1'b1);
         if (n == 2 * HB + 1) check("hb_hold", leds_a[0], 1'b1);
         if (n == 2 * HB + 2) check("hb_toggle2", leds_a[0], 1'b0);
      end

      check("a_orders", dbg_a.orders_sent, 16'(m_id));
      check("a_led75", leds_a[7:5], m_id[2:0]);
      check("a_position", {56'd0, dbg_a.position}, {56'd0, 8'(m_pos)});
      check("a_drops", dbg_a.drop_cnt, 16'd0);
      check("a_frames_drained", exp_q.size(), 0);

      // Abort an order in flight.
      for (int i = 0; i < 5000 && dbg_a.state != ST_SEND; i++) begin
         @(negedge clk);
         n++;
         model_step(n);
      end
      check("send_reached", dbg_a.state, ST_SEND);
      fr_before = frames[0];
      #1 rstn_raw = 1'b0;
      #1;
      check("abort_leds_a", leds_a, 8'h00);
      check("abort_leds_b", leds_b, 8'h00);
      check("abort_state", dbg_a.state, ST_IDLE);
      check("abort_lfsr", dbg_a.lfsr, SEED);
      check("abort_sent", dbg_a.orders_sent, 16'd0);
      repeat (12) @(negedge clk);
      exp_q.delete();
      rstn_raw = 1'b1;
      repeat (100) @(negedge clk);
      check("post_no_frame", frames[0], fr_before);
      check("post_sent", dbg_a.orders_sent, 16'd0);
      check("post_lfsr", dbg_a.lfsr, SEED);
      check("post_state", dbg_a.state, ST_IDLE);
      check("post_leds", leds_a, 8'h02);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
